// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: Moore control FSM and ALU decoder for the multicycle MIPS datapath
//   clk, reset (async, active-high); op/funct from the held IR; zero from the ALU
//   alucontrol: ALU F code; iord/alusrca/alusrcb/pcsrc/regdst/memtoreg: datapath mux selects
//   memwrite/irwrite/regwrite/pcen: write enables; illegal: one-cycle pulse when an instr is dropped
module mips_multicycle_ctrl #(
    parameter bit EN_BNE  = 1'b1,
    parameter int STATE_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [2:0] alucontrol,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic       illegal
);
    typedef enum logic [STATE_W-1:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
    } state_t;
    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_BNE = 6'b000101,
                           OP_ADDI = 6'b001000, OP_J = 6'b000010;
    logic [STATE_W-1:0] state, nxt;
    logic [1:0] aluop;
    logic pcwrite, branch, bne_br, functok, bne_ok;
    assign bne_ok = EN_BNE && op == OP_BNE;
    assign functok = funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    always_comb begin
        nxt = FETCH;
        case (state)
            FETCH:  nxt = DECODE;
            DECODE: nxt = (op == OP_LW || op == OP_SW) ? MEMADR :
                          op == OP_R ? EXEC :
                          (op == OP_BEQ || bne_ok) ? BRANCH :
                          op == OP_ADDI ? ADDIEX :
                          op == OP_J ? JUMP : FETCH;
            MEMADR: nxt = op == OP_LW ? MEMRD : MEMWR;
            MEMRD:  nxt = MEMWB;
            EXEC:   nxt = ALUWB;
            ADDIEX: nxt = ADDIWB;
            default: nxt = FETCH;
        endcase
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= FETCH;
        else state <= nxt;
    always_comb begin
        iord = 1'b0;
        memwrite = 1'b0;
        irwrite = 1'b0;
        regdst = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca = 1'b0;
        alusrcb = 2'b00;
        pcsrc = 2'b00;
        aluop = 2'b00;
        pcwrite = 1'b0;
        branch = 1'b0;
        bne_br = 1'b0;
        illegal = 1'b0;
        case (state)
            FETCH: begin
                alusrcb = 2'b01;
                irwrite = 1'b1;
                pcwrite = 1'b1;
            end
            DECODE: begin
                alusrcb = 2'b11;
                illegal = nxt == FETCH;
            end
            MEMADR, ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD: iord = 1'b1;
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                iord = 1'b1;
                memwrite = 1'b1;
            end
            EXEC: begin
                alusrca = 1'b1;
                aluop = 2'b10;
                illegal = !functok;
            end
            ALUWB: begin
                regdst = 1'b1;
                regwrite = functok;
            end
            BRANCH: begin
                alusrca = 1'b1;
                aluop = 2'b01;
                pcsrc = 2'b01;
                branch = op == OP_BEQ;
                bne_br = bne_ok;
            end
            ADDIWB: regwrite = 1'b1;
            JUMP: begin
                pcsrc = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
        // reset kills every enable at once, even though state already reads FETCH
        if (reset) begin
            memwrite = 1'b0;
            irwrite = 1'b0;
            regwrite = 1'b0;
            pcwrite = 1'b0;
            branch = 1'b0;
            bne_br = 1'b0;
            illegal = 1'b0;
        end
    end
    assign pcen = pcwrite | (branch & zero) | (bne_br & ~zero);
    always_comb
        alucontrol = aluop == 2'b01 ? 3'b110 :
                     aluop != 2'b10 ? 3'b010 :
                     funct == 6'b100010 ? 3'b110 :
                     funct == 6'b100100 ? 3'b000 :
                     funct == 6'b100101 ? 3'b001 :
                     funct == 6'b101010 ? 3'b111 : 3'b010;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed self-checking bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;
    logic clk = 1'b0, reset = 1'b1, zero = 1'b0;
    logic [5:0] op = 6'b100011, funct = 6'b000000;
    logic [2:0] alucontrol;
    logic [1:0] alusrcb, pcsrc;
    logic iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen, illegal;
    int passed = 0, total = 0;
    mips_multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .alucontrol(alucontrol), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .pcen(pcen), .illegal(illegal)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask
    task automatic step;
        @(negedge clk);
    endtask
    task automatic no_en(input string tag);
        chk({tag, "_en"}, {4'b0, memwrite, irwrite, regwrite, pcen}, 8'h00);
    endtask
    task automatic branch_test(input logic [5:0] o, input logic z, input logic exp_pcen);
        op = o;
        zero = z;
        step;
        step;
        chk("br_state", 8'(dut.state), 8'd8);
        chk("br_pcen", 8'(pcen), 8'(exp_pcen));
        chk("br_pcsrc", 8'(pcsrc), 8'h01);
        chk("br_alu", 8'(alucontrol), 8'h06);
        step;
        chk("br_back", 8'(dut.state), 8'd0);
    endtask
    logic [5:0] fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] fc [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    initial begin
        step;
        chk("rst_state", 8'(dut.state), 8'd0);
        no_en("rst");
        chk("rst_illegal", 8'(illegal), 8'h00);
        chk("rst_alu", 8'(alucontrol), 8'h02);
        chk("rst_srcb", 8'(alusrcb), 8'h01);
        reset = 1'b0;
        #1;
        chk("lw1_pcen", 8'(pcen), 8'h01);
        chk("lw1_ir", 8'(irwrite), 8'h01);
        chk("lw1_rw", {6'b0, regwrite, memtoreg}, 8'h00);
        step;
        chk("lw2_state", 8'(dut.state), 8'd1);
        chk("lw2_sig", {pcen, regwrite, memtoreg, 3'b0, alusrcb}, 8'h03);
        step;
        chk("lw3_state", 8'(dut.state), 8'd2);
        chk("lw3_sig", {pcen, regwrite, memtoreg, alusrca, 2'b0, alusrcb}, 8'h12);
        step;
        chk("lw4_state", 8'(dut.state), 8'd3);
        chk("lw4_sig", {pcen, regwrite, memtoreg, iord, 4'b0}, 8'h10);
        step;
        chk("lw5_state", 8'(dut.state), 8'd4);
        chk("lw5_sig", {pcen, regwrite, memtoreg, regdst, 4'b0}, 8'h60);
        step;
        chk("lw_back", 8'(dut.state), 8'd0);
        op = 6'b000000;
        for (int i = 0; i < 5; i++) begin
            funct = fn[i];
            step;
            step;
            chk("r_exec", 8'(dut.state), 8'd6);
            chk("r_alu", 8'(alucontrol), 8'(fc[i]));
            chk("r_ill", 8'(illegal), 8'h00);
            step;
            chk("r_wb", {regwrite, regdst, memtoreg, 5'b0}, 8'hC0);
            step;
        end
        branch_test(6'b000100, 1'b1, 1'b1);
        branch_test(6'b000100, 1'b0, 1'b0);
        branch_test(6'b000101, 1'b0, 1'b1);
        branch_test(6'b000101, 1'b1, 1'b0);
        zero = 1'b0;
        op = 6'b111111;
        step;
        chk("ill_state", 8'(dut.state), 8'd1);
        chk("ill_pulse", 8'(illegal), 8'h01);
        no_en("ill");
        step;
        chk("ill_back", 8'(dut.state), 8'd0);
        chk("ill_done", 8'(illegal), 8'h00);
        op = 6'b101011;
        step;
        step;
        chk("sw_adr", 8'(dut.state), 8'd2);
        reset = 1'b1;
        #1;
        chk("sw_rst_state", 8'(dut.state), 8'd0);
        no_en("sw_rst");
        step;
        chk("sw_rst_hold", 8'(dut.state), 8'd0);
        no_en("sw_rst2");
        reset = 1'b0;
        step;
        step;
        step;
        chk("sw_wr_state", 8'(dut.state), 8'd5);
        chk("sw_wr_sig", {memwrite, iord, regwrite, 5'b0}, 8'hC0);
        step;
        chk("sw_back", 8'(dut.state), 8'd0);
        op = 6'b001000;
        step;
        step;
        chk("addi_ex", {alusrca, alusrcb, alucontrol, 2'b0}, 8'hC8);
        step;
        chk("addi_wb", {regwrite, regdst, memtoreg, 5'b0}, 8'h80);
        step;
        op = 6'b000010;
        step;
        step;
        chk("j_state", 8'(dut.state), 8'd11);
        chk("j_sig", {pcen, 5'b0, pcsrc}, 8'h82);
        step;
        force dut.state = 4'b1111;
        #1;
        no_en("bad");
        chk("bad_ill", 8'(illegal), 8'h00);
        release dut.state;
        step;
        chk("bad_back", 8'(dut.state), 8'd0);
        op = 6'b000000;
        funct = 6'b000000;
        step;
        step;
        chk("rbad_ill", 8'(illegal), 8'h01);
        chk("rbad_alu", 8'(alucontrol), 8'h02);
        step;
        chk("rbad_state", 8'(dut.state), 8'd7);
        chk("rbad_rw", 8'(regwrite), 8'h00);
        step;
        chk("rbad_back", 8'(dut.state), 8'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
